// File: rtl/cpu_pkg.sv
// Shared core definitions: flush sequencer states, exception codes and the
// redirect target selection.
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DRAIN    = 2'd1,
      REDIRECT = 2'd2
   } flush_state_t;

   localparam logic [5:0] ECODE_INT = 6'h00;
   localparam logic [5:0] ECODE_SYS = 6'h0B;
   localparam logic [5:0] ECODE_BRK = 6'h0C;
   localparam logic [5:0] ECODE_INE = 6'h0D;

   // An exception outranks ertn when both retire in the same cycle.
   function automatic logic [31:0] flush_target(input logic        ex,
                                                input logic [31:0] eentry,
                                                input logic [31:0] era);
      return ex ? eentry : era;
   endfunction

endpackage

// File: rtl/ost_counter.sv
// Outstanding bus transaction counter: saturates at both ends and flags any
// overflow/underflow on a sticky error bit cleared only by reset.
module ost_counter #(
   parameter int OST_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req,
   input  logic             resp,
   output logic [OST_W-1:0] cnt,
   output logic             zero,
   output logic             err
);

   localparam logic [OST_W-1:0] CNT_MAX = '1;

   logic [OST_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (req && !resp) begin
         if (cnt_q == CNT_MAX) err_d = 1'b1;
         else                  cnt_d = cnt_q + 1'b1;
      end else if (resp && !req) begin
         if (cnt_q == '0) err_d = 1'b1;
         else             cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign cnt  = cnt_q;
   assign zero = (cnt_q == '0);
   assign err  = err_q;

endmodule

// File: rtl/flush_ctrl.sv
// Pipeline flush/redirect sequencer: kills younger stages on exception or
// ertn, drains in-flight SRAM transactions, then issues one PC redirect.
module flush_ctrl
   import cpu_pkg::*;
#(
   parameter int OST_W = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wb_ex,
   input  logic        ertn_flush,
   input  logic [31:0] csr_eentry,
   input  logic [31:0] csr_era,
   input  logic        inst_req_fire,
   input  logic        inst_resp_fire,
   input  logic        data_req_fire,
   input  logic        data_resp_fire,
   input  logic        redirect_ready,
   output logic        flush_pipe,
   output logic        wb_block,
   output logic        req_block,
   output logic        inst_resp_drop,
   output logic        data_resp_drop,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        busy,
   output logic        ost_err
);

   flush_state_t     state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic             evt, in_flush;
   logic [OST_W-1:0] inst_cnt, data_cnt;
   logic             inst_zero, data_zero, inst_err, data_err;

   ost_counter #(.OST_W(OST_W)) u_inst_ost (
      .clk   (clk),
      .reset (reset),
      .req   (inst_req_fire),
      .resp  (inst_resp_fire),
      .cnt   (inst_cnt),
      .zero  (inst_zero),
      .err   (inst_err)
   );

   ost_counter #(.OST_W(OST_W)) u_data_ost (
      .clk   (clk),
      .reset (reset),
      .req   (data_req_fire),
      .resp  (data_resp_fire),
      .cnt   (data_cnt),
      .zero  (data_zero),
      .err   (data_err)
   );

   assign evt = wb_ex | ertn_flush;

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      flush_pipe     = 1'b0;
      wb_block       = 1'b0;
      redirect_valid = 1'b0;
      case (state_q)
         IDLE: begin
            if (evt) begin
               flush_pipe = 1'b1;
               pc_d       = flush_target(wb_ex, csr_eentry, csr_era);
               state_d    = DRAIN;
            end
         end
         DRAIN: begin
            flush_pipe = 1'b1;
            wb_block   = 1'b1;
            if (inst_zero && data_zero) state_d = REDIRECT;
         end
         REDIRECT: begin
            flush_pipe     = 1'b1;
            wb_block       = 1'b1;
            redirect_valid = 1'b1;
            if (redirect_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // The zero flags must always agree with the counts they summarise.
   always_comb begin
      assert (inst_zero == (inst_cnt == '0));
      assert (data_zero == (data_cnt == '0));
   end

   assign in_flush       = (state_q == DRAIN) || (state_q == REDIRECT);
   assign busy           = (state_q != IDLE);
   assign req_block      = busy;
   assign inst_resp_drop = inst_resp_fire & in_flush;
   assign data_resp_drop = data_resp_fire & in_flush;
   assign redirect_pc    = pc_q;
   assign ost_err        = inst_err | data_err;

endmodule

// File: tb/tb_flush_ctrl.sv
// Scoreboard bench for flush_ctrl: stimulus queues expected redirects/drops,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_flush_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_ex, ertn_flush;
   logic [31:0] csr_eentry, csr_era;
   logic        inst_req_fire, inst_resp_fire, data_req_fire, data_resp_fire;
   logic        redirect_ready;
   logic        flush_pipe, wb_block, req_block, inst_resp_drop, data_resp_drop;
   logic        redirect_valid, busy, ost_err;
   logic [31:0] redirect_pc;

   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   logic [31:0] exp_pc[$];
   int          exp_cyc[$];
   int          inst_q[$];
   int          data_q[$];

   flush_ctrl #(.OST_W(2)) dut (
      .clk            (clk),
      .reset          (reset),
      .wb_ex          (wb_ex),
      .ertn_flush     (ertn_flush),
      .csr_eentry     (csr_eentry),
      .csr_era        (csr_era),
      .inst_req_fire  (inst_req_fire),
      .inst_resp_fire (inst_resp_fire),
      .data_req_fire  (data_req_fire),
      .data_resp_fire (data_resp_fire),
      .redirect_ready (redirect_ready),
      .flush_pipe     (flush_pipe),
      .wb_block       (wb_block),
      .req_block      (req_block),
      .inst_resp_drop (inst_resp_drop),
      .data_resp_drop (data_resp_drop),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .busy           (busy),
      .ost_err        (ost_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: redirect PC must match the queued target for every cycle it is
   // presented, and the handshake must land on the queued cycle.
   always @(negedge clk) begin
      if (!reset) begin
         if (redirect_valid) begin
            if (exp_pc.size() == 0) chk("unexpected_redirect", {31'd0, redirect_valid}, 32'd0);
            else begin
               chk("redirect_pc", redirect_pc, exp_pc[0]);
               if (redirect_ready) begin
                  chk("redirect_cycle", cyc, exp_cyc[0]);
                  void'(exp_pc.pop_front());
                  void'(exp_cyc.pop_front());
               end
            end
         end
         if (inst_resp_drop) begin
            if (inst_q.size() == 0) chk("unexpected_inst_drop", {31'd0, inst_resp_drop}, 32'd0);
            else chk("inst_drop_cycle", cyc, inst_q.pop_front());
         end
         if (data_resp_drop) begin
            if (data_q.size() == 0) chk("unexpected_data_drop", {31'd0, data_resp_drop}, 32'd0);
            else chk("data_drop_cycle", cyc, data_q.pop_front());
         end
      end
   end

   initial begin
      int n;
      reset = 1'b1; wb_ex = 1'b0; ertn_flush = 1'b0;
      csr_eentry = '0; csr_era = '0;
      inst_req_fire = 1'b0; inst_resp_fire = 1'b0;
      data_req_fire = 1'b0; data_resp_fire = 1'b0;
      redirect_ready = 1'b1;
      tick(); tick();
      chk("reset_ctrl_outs", {25'd0, flush_pipe, wb_block, req_block, inst_resp_drop,
                              data_resp_drop, redirect_valid, busy}, 32'd0);
      chk("reset_ost_err", {31'd0, ost_err}, 32'd0);
      chk("reset_redirect_pc", redirect_pc, 32'd0);
      reset = 1'b0;
      tick();

      // Exception with nothing outstanding
      wb_ex = 1'b1; csr_eentry = 32'h1C008000; n = cyc;
      exp_pc.push_back(32'h1C008000); exp_cyc.push_back(n + 2);
      #1;
      chk("t1_flush_comb", {31'd0, flush_pipe}, 32'd1);
      chk("t1_busy_n", {31'd0, busy}, 32'd0);
      tick(); wb_ex = 1'b0; #1;
      chk("t1_wb_block", {31'd0, wb_block}, 32'd1);
      chk("t1_req_block", {31'd0, req_block}, 32'd1);
      tick(); tick(); #1;
      chk("t1_idle_n3", {31'd0, busy}, 32'd0);

      // Drain wait
      inst_req_fire = 1'b1; tick();
      data_req_fire = 1'b1; tick();
      inst_req_fire = 1'b0; data_req_fire = 1'b0;
      ertn_flush = 1'b1; csr_era = 32'h1C000100; n = cyc;
      exp_pc.push_back(32'h1C000100); exp_cyc.push_back(n + 8);
      inst_q.push_back(n + 3); inst_q.push_back(n + 5); data_q.push_back(n + 6);
      tick(); ertn_flush = 1'b0;
      tick();
      tick(); inst_resp_fire = 1'b1;
      tick(); inst_resp_fire = 1'b0;
      tick(); inst_resp_fire = 1'b1;
      tick(); inst_resp_fire = 1'b0; data_resp_fire = 1'b1;
      tick(); data_resp_fire = 1'b0; #1;
      chk("t2_no_early_redirect", {31'd0, redirect_valid}, 32'd0);
      tick(); tick(); #1;
      chk("t2_idle", {31'd0, busy}, 32'd0);

      // Simultaneous exception and ertn
      wb_ex = 1'b1; ertn_flush = 1'b1; csr_eentry = 32'hA; csr_era = 32'hB; n = cyc;
      exp_pc.push_back(32'hA); exp_cyc.push_back(n + 2);
      tick(); wb_ex = 1'b0; ertn_flush = 1'b0;
      tick(); tick();

      // Redirect backpressure with ignored events
      redirect_ready = 1'b0; wb_ex = 1'b1; csr_eentry = 32'h100; n = cyc;
      exp_pc.push_back(32'h100); exp_cyc.push_back(n + 6);
      tick(); wb_ex = 1'b0;
      tick();
      tick(); csr_eentry = 32'h200; wb_ex = 1'b1;
      tick(); wb_ex = 1'b0; ertn_flush = 1'b1; csr_era = 32'h300;
      tick(); ertn_flush = 1'b0; #1;
      chk("t4_valid_held", {31'd0, redirect_valid}, 32'd1);
      tick(); redirect_ready = 1'b1;
      tick(); #1;
      chk("t4_idle", {31'd0, busy}, 32'd0);

      // Counter overflow then underflow
      chk("t5_err_clear", {31'd0, ost_err}, 32'd0);
      inst_req_fire = 1'b1;
      repeat (4) tick();
      inst_req_fire = 1'b0; #1;
      chk("t5_err_overflow", {31'd0, ost_err}, 32'd1);
      data_resp_fire = 1'b1; tick(); data_resp_fire = 1'b0; #1;
      chk("t5_err_sticky", {31'd0, ost_err}, 32'd1);
      wb_ex = 1'b1; csr_eentry = 32'h1C008000; n = cyc;
      exp_pc.push_back(32'h1C008000); exp_cyc.push_back(n + 5);
      inst_q.push_back(n + 1); inst_q.push_back(n + 2); inst_q.push_back(n + 3);
      tick(); wb_ex = 1'b0; inst_resp_fire = 1'b1;
      tick(); tick();
      tick(); inst_resp_fire = 1'b0;
      tick(); tick(); #1;
      chk("t5_idle", {31'd0, busy}, 32'd0);

      // Reset in DRAIN aborts the sequence
      inst_req_fire = 1'b1; tick(); tick(); inst_req_fire = 1'b0;
      wb_ex = 1'b1; csr_eentry = 32'h1C000200;
      tick(); wb_ex = 1'b0; reset = 1'b1;
      tick(); reset = 1'b0; #1;
      chk("t6_ctrl_outs", {25'd0, flush_pipe, wb_block, req_block, inst_resp_drop,
                           data_resp_drop, redirect_valid, busy}, 32'd0);
      chk("t6_ost_err", {31'd0, ost_err}, 32'd0);
      chk("t6_redirect_pc", redirect_pc, 32'd0);
      repeat (4) tick();
      wb_ex = 1'b1; csr_eentry = 32'h1C000400; n = cyc;
      exp_pc.push_back(32'h1C000400); exp_cyc.push_back(n + 2);
      tick(); wb_ex = 1'b0;
      tick(); tick(); #1;
      chk("t6_idle", {31'd0, busy}, 32'd0);

      tick();
      chk("redirect_q_empty", exp_pc.size(), 32'd0);
      chk("inst_drop_q_empty", inst_q.size(), 32'd0);
      chk("data_drop_q_empty", data_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
